// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit:
// FSM state encodings and the NOP instruction word.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_MC    = 2'd2;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter used for the performance counters.
// Ports: clk, rst (async active-low), inc (count enable), cnt (value).
module pipe_ctrl_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: hold/flush flags for PC, IF/ID and ID/EX, resolving
// jumps, load-use hazards, multi-cycle EX stalls and stall timeouts.
// Ports: clk, rst (async active-low); EX jump request and target; load-use
// register addresses; multi-cycle start/done; jump, hold, flush, abort and
// timeout flags out; saturating stall and flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MC_TIMEOUT   = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             ex_is_load_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             mc_start_i,
    input  logic             mc_done_i,
    output logic             jump_en_o,
    output logic [31:0]      jump_addr_o,
    output logic             hold_pc_o,
    output logic             hold_if_id_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             mc_abort_o,
    output logic             mc_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [1:0] state, state_d;
    logic [2:0] fcnt, fcnt_d;
    logic [7:0] tcnt, tcnt_d;
    logic       to_set;
    logic       hazard;

    assign hazard = ex_is_load_i && (ex_rd_addr_i != 5'd0) &&
                    ((ex_rd_addr_i == id_rs1_addr_i) ||
                     (ex_rd_addr_i == id_rs2_addr_i));

    always_comb begin
        state_d       = state;
        fcnt_d        = fcnt;
        tcnt_d        = tcnt;
        to_set        = 1'b0;
        jump_en_o     = 1'b0;
        jump_addr_o   = '0;
        hold_pc_o     = 1'b0;
        hold_if_id_o  = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        mc_abort_o    = 1'b0;
        // Flags are forced low while reset is held, even with live inputs.
        if (rst) begin
            if (jump_en_i) begin
                jump_en_o     = 1'b1;
                jump_addr_o   = jump_addr_i;
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
                mc_abort_o    = (state == ST_MC) || mc_start_i;
                if (FLUSH_CYCLES > 1) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = 3'(FLUSH_CYCLES - 1);
                end else begin
                    state_d = ST_RUN;
                end
            end else begin
                case (state)
                    ST_FLUSH: begin
                        flush_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                        fcnt_d        = fcnt - 3'd1;
                        if (fcnt == 3'd1) begin
                            state_d = ST_RUN;
                        end
                    end
                    ST_MC: begin
                        // Done or timeout both release the pipeline this cycle.
                        if (mc_done_i) begin
                            state_d = ST_RUN;
                        end else if (tcnt == 8'(MC_TIMEOUT - 1)) begin
                            mc_abort_o = 1'b1;
                            to_set     = 1'b1;
                            state_d    = ST_RUN;
                        end else begin
                            hold_pc_o     = 1'b1;
                            hold_if_id_o  = 1'b1;
                            flush_id_ex_o = 1'b1;
                            tcnt_d        = tcnt + 8'd1;
                        end
                    end
                    default: begin
                        if (mc_start_i) begin
                            hold_pc_o     = 1'b1;
                            hold_if_id_o  = 1'b1;
                            flush_id_ex_o = 1'b1;
                            state_d       = ST_MC;
                            tcnt_d        = 8'd0;
                        end else if (hazard) begin
                            hold_pc_o     = 1'b1;
                            hold_if_id_o  = 1'b1;
                            flush_id_ex_o = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_RUN;
            fcnt         <= 3'd0;
            tcnt         <= 8'd0;
            mc_timeout_o <= 1'b0;
        end else begin
            state <= state_d;
            fcnt  <= fcnt_d;
            tcnt  <= tcnt_d;
            if (to_set) begin
                mc_timeout_o <= 1'b1;
            end
        end
    end

    pipe_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hold_pc_o),
        .cnt (stall_cnt_o)
    );

    pipe_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (jump_en_o),
        .cnt (flush_cnt_o)
    );

endmodule
